// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the tile renderer:
//   - active-area and tile geometry constants
//   - default VRAM table bases (name, pattern, color)
//   - encoding of the tile fetch FSM states
// No ports; imported by tile_fetcher and tile_renderer.
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int ACTIVE_W    = 256;
    localparam int ACTIVE_H    = 192;
    localparam int TILE_SZ     = 8;
    localparam int VRAM_ADDR_W = 14;

    localparam logic [13:0] DEF_NAME_BASE    = 14'h1800;
    localparam logic [13:0] DEF_PATTERN_BASE = 14'h0000;
    localparam logic [13:0] DEF_COLOR_BASE   = 14'h2000;

    // Each state is named after the action taken on the edge that enters it.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NAME  = 3'd1,
        ST_WAITN = 3'd2,
        ST_PAT   = 3'd3,
        ST_WAITP = 3'd4,
        ST_COL   = 3'd5,
        ST_WAITC = 3'd6,
        ST_LATCH = 3'd7
    } fetch_state_e;

endpackage

// File: rtl/tile_fetcher.sv
// -----------------------------------------------------------------------------
// tile_fetcher
// Prefetches the name, pattern and color bytes of the tile one tile ahead of
// the current pixel column through a single synchronous-read VRAM port.
//
// Ports:
//   i_clk, i_rst      pixel clock, asynchronous active-high reset
//   i_xpos, i_ypos    signed 9-bit pixel column / line from the sync generator
//   i_vram_data       VRAM read data, valid one cycle after the address cycle
//   i_load            renderer consumes the staged tile on this edge
//   o_vram_addr       registered VRAM read address
//   o_vram_read       read strobe, high from NAME through WAITC
//   o_next_pat        staged pattern byte for the next tile
//   o_next_col        staged color byte for the next tile
//   o_next_vld        staged tile is complete and not yet consumed
//   o_state           current fetch FSM state (debug visibility)
//
// Handshake: the fetcher sets o_next_vld on the LATCH edge; the renderer
// consumes the staged bytes on any edge where i_load is high, which clears
// o_next_vld. If both happen on one edge the new tile wins.
// -----------------------------------------------------------------------------
module tile_fetcher
    import video_pkg::*;
#(
    parameter int                ADDR_W       = VRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] NAME_BASE    = ADDR_W'(DEF_NAME_BASE),
    parameter logic [ADDR_W-1:0] PATTERN_BASE = ADDR_W'(DEF_PATTERN_BASE),
    parameter logic [ADDR_W-1:0] COLOR_BASE   = ADDR_W'(DEF_COLOR_BASE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [8:0]        i_xpos,
    input  logic [8:0]        i_ypos,
    input  logic [7:0]        i_vram_data,
    input  logic              i_load,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic              o_vram_read,
    output logic [7:0]        o_next_pat,
    output logic [7:0]        o_next_col,
    output logic              o_next_vld,
    output fetch_state_e      o_state
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;

    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_read;
    logic [4:0]        r_tile_grp;
    logic [7:0]        r_next_pat;
    logic [7:0]        r_next_col;
    logic              r_next_vld;

    logic [5:0]        w_lx_tile;
    logic [2:0]        w_slot;
    logic              w_fetchable;
    logic [ADDR_W-1:0] w_name_addr;
    logic [ADDR_W-1:0] w_pat_addr;
    logic [ADDR_W-1:0] w_col_addr;

    // Lookahead column lx = xPos + 8 (9-bit wrap). Adding 8 leaves bits [2:0]
    // untouched, so only lx[8:3] is formed: it is xPos[8:3] + 1.
    assign w_lx_tile   = i_xpos[8:3] + 6'd1;
    assign w_slot      = i_xpos[2:0];
    assign w_fetchable = !w_lx_tile[5] && !i_ypos[8] && (i_ypos < 9'(ACTIVE_H));

    assign w_name_addr = NAME_BASE    + ADDR_W'({i_ypos[7:3], w_lx_tile[4:0]});
    // The tile number is used straight off the RAM bus in the PAT cycle.
    assign w_pat_addr  = PATTERN_BASE + ADDR_W'({i_vram_data, i_ypos[2:0]});
    // One color byte covers eight consecutive tile numbers.
    assign w_col_addr  = COLOR_BASE   + ADDR_W'(r_tile_grp);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_slot == 3'd0 && w_fetchable) begin
                    w_next_state = ST_NAME;
                end
            end
            ST_NAME:  w_next_state = ST_WAITN;
            ST_WAITN: w_next_state = ST_PAT;
            ST_PAT:   w_next_state = ST_WAITP;
            ST_WAITP: w_next_state = ST_COL;
            ST_COL:   w_next_state = ST_WAITC;
            ST_WAITC: w_next_state = ST_LATCH;
            ST_LATCH: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_vram_addr <= '0;
            r_vram_read <= 1'b0;
            r_tile_grp  <= '0;
            r_next_pat  <= '0;
            r_next_col  <= '0;
            r_next_vld  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_vram_read <= (w_next_state != ST_IDLE) && (w_next_state != ST_LATCH);

            if (i_load) begin
                r_next_vld <= 1'b0;
            end

            case (w_next_state)
                ST_NAME: begin
                    r_vram_addr <= w_name_addr;
                end
                ST_PAT: begin
                    r_tile_grp  <= i_vram_data[7:3];
                    r_vram_addr <= w_pat_addr;
                end
                ST_COL: begin
                    r_next_pat  <= i_vram_data;
                    r_vram_addr <= w_col_addr;
                end
                ST_LATCH: begin
                    r_next_col  <= i_vram_data;
                    r_next_vld  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_vram_addr = r_vram_addr;
    assign o_vram_read = r_vram_read;
    assign o_next_pat  = r_next_pat;
    assign o_next_col  = r_next_col;
    assign o_next_vld  = r_next_vld;
    assign o_state     = r_state;

endmodule

// File: rtl/tile_renderer.sv
// -----------------------------------------------------------------------------
// tile_renderer
// Renders a 32x24 grid of 8x8 tiles (256x192 active area) from VRAM and emits
// one 4-bit palette index per pixel clock, with the sync stream delayed by one
// cycle so it stays aligned with the pixels.
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   xPos, yPos          signed 9-bit pixel column / line
//   isActive            high inside the 256x192 region
//   hSyncIn, vSyncIn    sync inputs
//   fineX               fine horizontal scroll (only with the macro below)
//   backdrop            color for index 0 and outside the active region
//   vramAddr, vramRead  VRAM read port (registered)
//   vramData            VRAM data, valid one cycle after the address cycle
//   pixelColor          palette index
//   hSyncOut, vSyncOut  sync delayed to match pixelColor
//   activeOut           isActive delayed to match pixelColor
//
// Build option: TILE_RENDERER_SCROLL_EN adds the fineX input, rotates the
// pixel select by fineX and moves the tile load edge to slot 7 - fineX.
// -----------------------------------------------------------------------------
module tile_renderer
    import video_pkg::*;
#(
    parameter int                ADDR_W       = VRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] NAME_BASE    = ADDR_W'(DEF_NAME_BASE),
    parameter logic [ADDR_W-1:0] PATTERN_BASE = ADDR_W'(DEF_PATTERN_BASE),
    parameter logic [ADDR_W-1:0] COLOR_BASE   = ADDR_W'(DEF_COLOR_BASE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        xPos,
    input  logic [8:0]        yPos,
    input  logic              isActive,
    input  logic              hSyncIn,
    input  logic              vSyncIn,
`ifdef TILE_RENDERER_SCROLL_EN
    input  logic [2:0]        fineX,
`endif
    input  logic [3:0]        backdrop,
    output logic [ADDR_W-1:0] vramAddr,
    output logic              vramRead,
    input  logic [7:0]        vramData,
    output logic [3:0]        pixelColor,
    output logic              hSyncOut,
    output logic              vSyncOut,
    output logic              activeOut
);

    logic [7:0]   w_next_pat;
    logic [7:0]   w_next_col;
    logic         w_next_vld;
    fetch_state_e w_unused_fetch_state;

    logic [7:0]   r_cur_pat;
    logic [7:0]   r_cur_col;
    logic [3:0]   r_pixel;
    logic         r_hsync;
    logic         r_vsync;
    logic         r_active;

    logic [2:0]   w_slot;
    logic [2:0]   w_sel;
    logic         w_load;
    logic         w_bit;
    logic [3:0]   w_color;

    tile_fetcher #(
        .ADDR_W       (ADDR_W),
        .NAME_BASE    (NAME_BASE),
        .PATTERN_BASE (PATTERN_BASE),
        .COLOR_BASE   (COLOR_BASE)
    ) u_fetcher (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_xpos      (xPos),
        .i_ypos      (yPos),
        .i_vram_data (vramData),
        .i_load      (w_load),
        .o_vram_addr (vramAddr),
        .o_vram_read (vramRead),
        .o_next_pat  (w_next_pat),
        .o_next_col  (w_next_col),
        .o_next_vld  (w_next_vld),
        .o_state     (w_unused_fetch_state)
    );

    assign w_slot = xPos[2:0];

`ifdef TILE_RENDERER_SCROLL_EN
    // 3-bit sum wraps, giving (slot + fineX) mod 8.
    assign w_sel  = w_slot + fineX;
    assign w_load = (w_slot == (3'd7 - fineX));
`else
    assign w_sel  = w_slot;
    assign w_load = (w_slot == 3'd7);
`endif

    // Pattern bit 7 is the leftmost pixel of the tile.
    assign w_bit   = r_cur_pat[3'd7 - w_sel];
    assign w_color = w_bit ? r_cur_col[7:4] : r_cur_col[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_pat <= '0;
            r_cur_col <= '0;
            r_pixel   <= '0;
            r_hsync   <= 1'b0;
            r_vsync   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            // A tile that was never fetched loads as zero: all backdrop.
            if (w_load) begin
                r_cur_pat <= w_next_vld ? w_next_pat : 8'h00;
                r_cur_col <= w_next_vld ? w_next_col : 8'h00;
            end
            r_pixel  <= (isActive && (w_color != 4'd0)) ? w_color : backdrop;
            r_hsync  <= hSyncIn;
            r_vsync  <= vSyncIn;
            r_active <= isActive;
        end
    end

    assign pixelColor = r_pixel;
    assign hSyncOut   = r_hsync;
    assign vSyncOut   = r_vsync;
    assign activeOut  = r_active;

endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Downstream of the sync generator. Consumes its xPos/yPos/isActive/hSync/vSync stream and produces one 4-bit palette index per clk.
- Renders a 32x24 grid of 8x8 tiles (256x192 active area) from VRAM, using a name table, a pattern table and a color table.
- Tile data is prefetched one tile ahead through a single synchronous-read VRAM port. Sync signals are delayed so they stay aligned with the pixels.

Parameters:
- NAME_BASE, 14'h1800: VRAM base of the 768-byte name table.
- PATTERN_BASE, 14'h0000: VRAM base of the 2048-byte pattern table.
- COLOR_BASE, 14'h2000: VRAM base of the 32-byte color table.
- ADDR_W, 14: VRAM address width.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- xPos  in  9  signed pixel column from the sync generator
- yPos  in  9  signed pixel line from the sync generator
- isActive  in  1  high inside the 256x192 region
- hSyncIn  in  1  horizontal sync from the sync generator
- vSyncIn  in  1  vertical sync from the sync generator
- backdrop  in  4  color used for color index 0 and outside the active region
- vramAddr  out  ADDR_W  registered read address
- vramRead  out  1  read strobe
- vramData  in  8  read data, valid exactly 1 cycle after the address cycle
- pixelColor  out  4  palette index
- hSyncOut  out  1  hSyncIn delayed to match pixelColor
- vSyncOut  out  1  vSyncIn delayed to match pixelColor
- activeOut  out  1  isActive delayed to match pixelColor

Behaviour:
- Reset clears all registers: vramAddr=0, vramRead=0, pixelColor=0, hSyncOut=0, vSyncOut=0, activeOut=0, and the tile/pattern/color registers. The fetch FSM returns to IDLE.
- Reset mid-line: output stays 0. The first valid fetch restarts at the next slot-0 cycle.
- Latency: every output is registered and reflects the inputs of the previous cycle (1 cycle).
- Lookahead column lx = xPos + 8, computed 9-bit with wrap. lx is fetchable when lx[8]==0, yPos[8]==0 and yPos<192.
- xPos -8..-1 gives lx 0..7, so tile 0 is fetched before the line starts. xPos 248..255 gives lx >= 256, so no fetch occurs.
- Slot = xPos[2:0]. The fetch FSM advances one state per clk:
  - IDLE: wait for slot 0 with lx fetchable, then go to NAME.
  - NAME (issued at the slot-0 edge): vramAddr <= NAME_BASE + {yPos[7:3], lx[7:3]}, vramRead=1. Go to WAITN.
  - WAITN: idle cycle for the RAM. Go to PAT.
  - PAT: tile <= vramData; vramAddr <= PATTERN_BASE + {tile, yPos[2:0]}, with the tile taken from vramData. Go to WAITP.
  - WAITP: idle cycle for the RAM. Go to COL.
  - COL: nextPat <= vramData; vramAddr <= COLOR_BASE + tile[7:3]. Go to WAITC.
  - WAITC: idle cycle for the RAM. Go to LATCH.
  - LATCH: nextCol <= vramData; vramRead=0. Go to IDLE.
  - LATCH is reached at slot 6, which is before the slot-7 edge.
- vramRead is high from NAME through WAITC and low otherwise.
- Load: at the edge where input slot==7, curPat <= nextPat and curCol <= nextCol.
  - If no fetch occurred for this tile, they load 0, which renders as all-backdrop.
- Pixel: at each edge, bit = curPat[7 - xPos[2:0]] and c = bit ? curCol[7:4] : curCol[3:0].
  - pixelColor <= (isActive && c!=0) ? c : backdrop.
- Width rules: all address sums are ADDR_W bits and wrap modulo 2^ADDR_W. Slot and sync values come straight from the input bits.
- Simultaneous events: a slot-7 load and a LATCH in the same cycle cannot occur, because LATCH is always at slot 6.

Optional Feature:
- Macro TILE_RENDERER_SCROLL_EN.
- Defined: adds input fineX[2:0]. The pixel select becomes curPat[7 - ((xPos[2:0] + fineX) mod 8)], and the load edge becomes slot == (7 - fineX). The fetch still completes by slot 6 relative to xPos; nextPat/nextCol are held until the load edge.
- Undefined: no fineX port, and behaviour is exactly as described above.

Decomposition:
- Shared package video_pkg holds:
  - constants ACTIVE_W=256, ACTIVE_H=192, TILE_SZ=8;
  - the FSM state encoding (IDLE, NAME, WAITN, PAT, WAITP, COL, WAITC, LATCH);
  - default table bases.
- One natural sub-module, tile_fetcher, owns the FSM, vramAddr/vramRead and nextPat/nextCol. The top level keeps the load, pixel mux and sync delay.

Test Plan:
- Reset asserted mid-fetch at xPos=3 -> all outputs 0 immediately and asynchronously. After release, the first NAME is at the next slot 0 with lx fetchable.
- Name[0]=0x41, pattern[0x41*8+0]=0xA5, color[8]=0xF4, row yPos=0 -> over xPos 0..7, pixelColor one cycle later = F,4,F,4,4,F,4,F.
- Same tile with color[8]=0x04, backdrop=9 -> foreground pixels (bit 1) output 9 and background pixels (bit 0) output 4.
- xPos=-8, yPos=10 -> vramAddr = 0x1800 + {5'd1, 5'd0} = 0x1820. xPos=248 -> no vramRead for the rest of the line.
- yPos=192 with isActive=0 -> no VRAM reads and pixelColor=backdrop. A hSyncIn pulse appears on hSyncOut exactly 1 cycle later; vSyncOut likewise.
- With TILE_RENDERER_SCROLL_EN, fineX=3, pattern 0x80 -> the single foreground pixel appears at xPos=5.
